// File: rtl/alu_server.sv
// alu_server: a small ALU shared by two clients through a round-robin arbiter.
// A granted request's operands are captured at accept. ADD/OR/SRL/SLTU/SUB
// take one clock; MUL is an 8-clock shift-add. The owner then gets a one-cycle
// done strobe while res_o holds the result.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-low reset
//   reqN_i, aN_i, bN_i, opN_i  client N request, operands and opcode (N = 0, 1)
//   res_o                   shared result register, held between operations
//   done0_o, done1_o        one-cycle completion strobe per client
//   busy_o                  high whenever the FSM is not in IDLE
module alu_server (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_i,
    input  logic [7:0] a0_i,
    input  logic [7:0] b0_i,
    input  logic [2:0] op0_i,
    input  logic       req1_i,
    input  logic [7:0] a1_i,
    input  logic [7:0] b1_i,
    input  logic [2:0] op1_i,
    output logic [7:0] res_o,
    output logic       done0_o,
    output logic       done1_o,
    output logic       busy_o
);

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 3;
    localparam int unsigned CW = 3;

    // Opcode encoding shared with the CPU's ALU.
    localparam logic [OW-1:0] ALU_ADD  = 3'b000;
    localparam logic [OW-1:0] ALU_OR   = 3'b001;
    localparam logic [OW-1:0] ALU_SRL  = 3'b010;
    localparam logic [OW-1:0] ALU_SLTU = 3'b011;
    localparam logic [OW-1:0] ALU_SUB  = 3'b100;
    localparam logic [OW-1:0] ALU_MUL  = 3'b111;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
    logic [OW-1:0] op_q, op_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d, last_q, last_d;
    logic          done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
    logic [DW-1:0] exec_res;
    logic          grant;

    // Single-cycle ALU on the captured operands; the shift uses all bits of b.
    always_comb begin
        exec_res = '0;
        case (op_q)
            ALU_ADD:  exec_res = a_q + b_q;
            ALU_OR:   exec_res = a_q | b_q;
            ALU_SRL:  exec_res = a_q >> b_q;
            ALU_SLTU: exec_res = DW'(a_q < b_q);
            ALU_SUB:  exec_res = a_q - b_q;
            default:  exec_res = '0;
        endcase
    end

    // Next-state, arbitration and datapath updates.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        // On a tie the client not served last wins; otherwise the lone requester.
        grant   = (req0_i && req1_i) ? ~last_q : req1_i;

        case (state_q)
            IDLE: begin
                if (req0_i || req1_i) begin
                    owner_d = grant;
                    last_d  = grant;
                    a_d     = grant ? a1_i : a0_i;
                    b_d     = grant ? b1_i : b0_i;
                    op_d    = grant ? op1_i : op0_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ((grant ? op1_i : op0_i) == ALU_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                res_d   = exec_res;
                done0_d = ~owner_q;
                done1_d = owner_q;
                state_d = DONE;
            end
            MUL: begin
                // Multiplicand shifts left, multiplier shifts right; 8 steps total.
                acc_d = acc_q + (b_q[0] ? a_q : DW'(0));
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(7)) begin
                    res_d   = acc_d;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            busy_q  <= busy_d;
        end
    end

    assign res_o   = res_q;
    assign done0_o = done0_q;
    assign done1_o = done1_q;
    assign busy_o  = busy_q;

endmodule
